fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 128: instruction-memory depth in words; valid PCs are 0..MEM_WORDS-1.
REQ-002 The block SHALL have parameter QDEPTH, default 2: prefetch queue depth; power of two, minimum 2.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
REQ-004 Control ports SHALL be:
- start  in  1  begin fetching at start_pc; honoured only in IDLE or HALT.
- start_pc  in  32  word-indexed start address.
- redirect  in  1  branch/jump redirect; honoured only in RUN or DRAIN.
- redirect_pc  in  32  word-indexed redirect target.
REQ-005 Memory ports SHALL be:
- imem_pc  out  32  word index driven to the instruction memory.
- imem_instr  in  32  instruction word, combinational from imem_pc.
- imem_done  in  1  end-of-program flag, combinational from imem_pc.
REQ-006 Consumer and status ports SHALL be:
- out_valid  out  1  queue head valid.
- out_ready  in  1  consumer accepts the head.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- busy  out  1  state is RUN or DRAIN.
- halted  out  1  state is HALT.
- fault  out  1  sticky out-of-range fetch flag.

Function
REQ-007 The FSM SHALL have states IDLE, RUN, DRAIN and HALT, held in a registered state variable.
REQ-008 imem_pc SHALL be the registered fetch PC (fetch_pc).
REQ-009 IDLE or HALT with start=1 SHALL, next cycle:
- set fetch_pc=start_pc;
- flush the queue;
- clear fault;
- enter RUN.
REQ-010 In RUN, a fetch SHALL occur when the queue has space: count<QDEPTH, or count==QDEPTH with a pop this cycle.
REQ-011 A fetch with imem_done=0 and fetch_pc<MEM_WORDS SHALL push {fetch_pc, imem_instr} and set fetch_pc<=fetch_pc+1.
REQ-012 A fetch-eligible cycle with imem_done=1 SHALL push nothing, hold fetch_pc, and enter DRAIN.
REQ-013 In RUN, fetch_pc>=MEM_WORDS SHALL push nothing, set fault=1, and enter DRAIN; this check takes priority over imem_done.
REQ-014 In RUN with a full queue and no pop, the block SHALL stall: no push, fetch_pc held.
REQ-015 DRAIN SHALL make no fetches and SHALL enter HALT on the cycle after count reaches 0.
REQ-016 Consumer handshake:
- out_valid=1 exactly when count>0;
- a pop occurs when out_valid&&out_ready;
- out_instr/out_pc SHALL be stable while out_valid=1 and out_ready=0.
REQ-017 Push and pop in the same cycle SHALL leave count unchanged, and entry order SHALL be preserved.
REQ-018 Push SHALL never occur when full; a pop with out_valid=0 SHALL have no effect.
REQ-019 redirect=1 in RUN or DRAIN SHALL, next cycle:
- discard all queue entries, so count=0 (a pop in the same cycle completes normally);
- suppress that cycle's push;
- set fetch_pc=redirect_pc;
- enter RUN.
REQ-020 redirect SHALL take priority over the imem_done and out-of-range transitions; fault SHALL keep its value.
REQ-021 redirect in IDLE or HALT, and start in RUN or DRAIN, SHALL be ignored.
REQ-022 Fetch PC arithmetic SHALL be 32-bit unsigned and wrap 0xFFFFFFFF->0; the out-of-range rule catches this before reuse.
REQ-023 The out_valid-to-consumer path SHALL be combinational only from registered state; a fetch SHALL appear at the queue head no earlier than the cycle after its push.

Reset
REQ-024 rst=1 SHALL immediately, asynchronously, force:
- state=IDLE, fetch_pc=0, imem_pc=0;
- count=0, out_valid=0;
- busy=0, halted=0, fault=0.
REQ-025 Reset asserted mid-operation SHALL discard all queued entries.
REQ-026 The first cycle after rst deassertion SHALL honour start.

Verification
REQ-027 Streaming: start_pc=0; memory words 0..4 valid, word 5 done; out_ready=1 -> out_pc 0,1,2,3,4 in order with matching instr; halted=1 within 2 cycles of the last pop; fault=0.
REQ-028 Backpressure: out_ready=0 for 6 cycles after start -> count saturates at QDEPTH=2, imem_pc holds 2, out_pc=0 stable; after release, the sequence continues 0,1,2,... with no loss or duplication.
REQ-029 Redirect: while entries pc=3,4 are queued, pulse redirect with redirect_pc=20 -> next cycle out_valid=0 and imem_pc=20; the next output is pc=20; pc=3 and pc=4 are never delivered unless popped in the redirect cycle.
REQ-030 Out-of-range: MEM_WORDS=8, start_pc=6, no done marker -> outputs pc 6,7, then fault=1 and halted=1; a new start clears fault.
REQ-031 Async reset: assert rst between clock edges during RUN with count=2 -> out_valid, busy and count go to 0 before the next edge; state=IDLE.
REQ-032 Simultaneous events: redirect=1 with imem_done=1 on the same cycle -> state RUN at the redirect target, not DRAIN; start during RUN -> no effect.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, its instruction memory,
// the controlling host and the instruction consumer.
interface fetch_sequencer_if;
  logic        start;
  logic [31:0] start_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        imem_done;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        busy;
  logic        halted;
  logic        fault;

  modport slave (
    input  start, start_pc, redirect, redirect_pc,
    input  imem_instr, imem_done, out_ready,
    output imem_pc, out_valid, out_instr, out_pc, busy, halted, fault
  );

  modport master (
    output start, start_pc, redirect, redirect_pc,
    output imem_instr, imem_done, out_ready,
    input  imem_pc, out_valid, out_instr, out_pc, busy, halted, fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a word-indexed instruction memory into a
// small prefetch FIFO, with start/redirect control and an end-of-program drain.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | fetching into the queue while space allows
// DRAIN | no more fetches, waiting for the consumer to empty the queue
// HALT  | program finished (or faulted), waiting for a new start
module fetch_sequencer #(
  parameter int MEM_WORDS = 128,
  parameter int QDEPTH    = 2
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.slave bus
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          fault_q;
  logic          busy_q;
  logic          halted_q;

  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];

  logic          queue_valid;
  logic          pop;
  logic          has_space;
  logic          in_range;
  logic          do_start;
  logic          do_redirect;
  logic          push;

  assign queue_valid = (count != '0);
  assign pop         = queue_valid && bus.out_ready;
  assign has_space   = (count < CW'(QDEPTH)) || pop;
  assign in_range    = (fetch_pc < 32'(MEM_WORDS));
  assign do_start    = bus.start && ((state == IDLE) || (state == HALT));
  assign do_redirect = bus.redirect && ((state == RUN) || (state == DRAIN));

  // Range check outranks imem_done, and a redirect suppresses the push outright.
  assign push = (state == RUN) && !do_redirect && in_range && has_space
                && !bus.imem_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);

      case (state)
        IDLE, HALT: begin
          if (do_start) begin
            state    <= RUN;
            fetch_pc <= bus.start_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fault_q  <= 1'b0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end

        RUN: begin
          if (do_redirect) begin
            fetch_pc <= bus.redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
          end else if (!in_range) begin
            fault_q <= 1'b1;
            state   <= DRAIN;
          end else if (has_space) begin
            if (bus.imem_done) state <= DRAIN;
            else               fetch_pc <= fetch_pc + 32'd1;
          end
        end

        DRAIN: begin
          if (do_redirect) begin
            state    <= RUN;
            fetch_pc <= bus.redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
          end else if (count == '0) begin
            state    <= HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= fetch_pc;
      q_instr[wr_ptr] <= bus.imem_instr;
    end
  end

  assign bus.imem_pc   = fetch_pc;
  assign bus.out_valid = queue_valid;
  assign bus.out_pc    = q_pc[rd_ptr];
  assign bus.out_instr = q_instr[rd_ptr];
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.fault     = fault_q;

endmodule
